page_program_seq: RTL and testbench

//  Command sequencer for the flash address/buffer datapath. Takes decoded opcodes and
//  per-beat strobes from the SPI/OPI front end and drives en_addr, en_write_buf,
//  en_read_buf, save_start_addr and en_wr. Runs Page Program (buffer load, then

---
 rtl/flash_pkg.sv | 28 ++
 rtl/page_program_seq.sv | 195 +++++++++++++++++++
 tb/tb_page_program_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash command sequencer.
//   state_t    : sequencer states
//   op_t       : latched operation kind (page program or read)
//   OP_PP      : page-program opcode
//   OP_READ    : read opcode
//   PAGE_BYTES : program buffer depth in bytes
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_UNLOAD,
    ST_PSTART,
    ST_PROG,
    ST_DONE
  } state_t;

  typedef enum logic {
    OPK_PP,
    OPK_RD
  } op_t;

  localparam logic [7:0]  OP_PP      = 8'h02;
  localparam logic [7:0]  OP_READ    = 8'h03;
  localparam int unsigned PAGE_BYTES = 256;

endpackage

// File: rtl/page_program_seq.sv
// Command sequencer for the flash address/buffer datapath.
// Runs Page Program (address, buffer load, array write) and Read
// (address, buffer unload).
// Ports:
//   clkm            system clock, posedge
//   rst_n           synchronous active-low reset
//   cmd_valid/cmd   one-cycle decoded opcode strobe
//   mode            0 = SPI (bit per beat), 1 = OPI (byte per beat); sampled at cmd_valid
//   beat            one-cycle pulse per transferred beat
//   cs_end          one-cycle pulse on chip-select deassertion
//   wel             write-enable latch
//   mem_ready       array ready for the next program byte
//   en_addr         address shift enable (combinational)
//   en_write_buf    buffer write enable (combinational)
//   en_read_buf     buffer read enable (combinational)
//   save_start_addr one-cycle pulse at program start
//   en_wr           one-cycle pulse per byte written to the array
//   busy            high while programming
//   prog_done       one-cycle pulse on completion
//   wel_clr         one-cycle pulse with prog_done
//   err             one-cycle pulse on an aborted or refused command
module page_program_seq #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter logic [7:0]  OP_PP      = flash_pkg::OP_PP,
  parameter logic [7:0]  OP_READ    = flash_pkg::OP_READ,
  parameter int unsigned PAGE_BYTES = flash_pkg::PAGE_BYTES
) (
  input  logic       clkm,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  input  logic       mode,
  input  logic       beat,
  input  logic       cs_end,
  input  logic       wel,
  input  logic       mem_ready,
  output logic       en_addr,
  output logic       en_write_buf,
  output logic       en_read_buf,
  output logic       save_start_addr,
  output logic       en_wr,
  output logic       busy,
  output logic       prog_done,
  output logic       wel_clr,
  output logic       err
);
  import flash_pkg::*;

  localparam int unsigned BCW = $clog2(ADDR_BITS);
  localparam int unsigned LCW = $clog2(PAGE_BYTES + 1);
  localparam logic [BCW-1:0] LAST_SPI = BCW'(ADDR_BITS - 1);
  localparam logic [BCW-1:0] LAST_OPI = BCW'(ADDR_BITS / 8 - 1);
  localparam logic [LCW-1:0] LOAD_MAX = LCW'(PAGE_BYTES);

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic           mode_q, mode_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LCW-1:0] load_cnt_q, load_cnt_d;
  logic [LCW-1:0] prog_cnt_q, prog_cnt_d;
  logic           save_q, save_d;
  logic           en_wr_q, en_wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           data_strobe;
  logic [BCW-1:0] addr_last;

  // In the data phases beat_cnt is reused as the bit-in-byte counter.
  assign data_strobe = beat && (mode_q || (beat_cnt_q[2:0] == 3'd7));
  assign addr_last   = mode_q ? LAST_OPI : LAST_SPI;

  assign en_addr      = (state_q == ST_ADDR)   && beat;
  assign en_write_buf = (state_q == ST_LOAD)   && data_strobe;
  assign en_read_buf  = (state_q == ST_UNLOAD) && data_strobe;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mode_d     = mode_q;
    beat_cnt_d = beat_cnt_q;
    load_cnt_d = load_cnt_q;
    prog_cnt_d = prog_cnt_q;
    en_wr_d    = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd == OP_PP) begin
            if (wel) begin
              state_d    = ST_ADDR;
              op_d       = OPK_PP;
              mode_d     = mode;
              beat_cnt_d = '0;
              load_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (cmd == OP_READ) begin
            state_d    = ST_ADDR;
            op_d       = OPK_RD;
            mode_d     = mode;
            beat_cnt_d = '0;
            load_cnt_d = '0;
          end
        end
      end

      ST_ADDR: begin
        if (beat && (beat_cnt_q == addr_last)) begin
          state_d    = (op_q == OPK_PP) ? ST_LOAD : ST_UNLOAD;
          beat_cnt_d = '0;
        end else begin
          if (beat) beat_cnt_d = beat_cnt_q + BCW'(1);
          if (cs_end) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (beat) beat_cnt_d = beat_cnt_q + BCW'(1);
        if (en_write_buf && (load_cnt_q != LOAD_MAX)) load_cnt_d = load_cnt_q + LCW'(1);
        // A beat coinciding with cs_end is counted before deciding.
        if (cs_end) state_d = (load_cnt_d != '0) ? ST_PSTART : ST_IDLE;
      end

      ST_UNLOAD: begin
        if (beat) beat_cnt_d = beat_cnt_q + BCW'(1);
        if (cs_end) state_d = ST_IDLE;
      end

      ST_PSTART: begin
        prog_cnt_d = '0;
        state_d    = ST_PROG;
      end

      ST_PROG: begin
        // en_wr_q blocks back-to-back pulses so mem_ready is re-sampled.
        if (prog_cnt_q == load_cnt_q) begin
          state_d = ST_DONE;
        end else if (mem_ready && !en_wr_q) begin
          en_wr_d    = 1'b1;
          prog_cnt_d = prog_cnt_q + LCW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    save_d = (state_d == ST_PSTART);
    busy_d = (state_d == ST_PSTART) || (state_d == ST_PROG);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clkm) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OPK_PP;
      mode_q     <= 1'b0;
      beat_cnt_q <= '0;
      load_cnt_q <= '0;
      prog_cnt_q <= '0;
      save_q     <= 1'b0;
      en_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mode_q     <= mode_d;
      beat_cnt_q <= beat_cnt_d;
      load_cnt_q <= load_cnt_d;
      prog_cnt_q <= prog_cnt_d;
      save_q     <= save_d;
      en_wr_q    <= en_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign save_start_addr = save_q;
  assign en_wr           = en_wr_q;
  assign busy            = busy_q;
  assign prog_done       = done_q;
  assign wel_clr         = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_page_program_seq.sv
// Self-checking bench for page_program_seq: directed scenarios followed by
// randomized transactions, each compared against per-transaction event counts
// derived from the command rules.
module tb_page_program_seq;
  import flash_pkg::*;

  localparam int NB_SPI = 32;
  localparam int NB_OPI = 4;

  logic clkm = 1'b0;
  always #5 clkm = ~clkm;

  logic       rst_n, cmd_valid, mode, beat, cs_end, wel, mem_ready;
  logic [7:0] cmd;
  logic       en_addr, en_write_buf, en_read_buf, save_start_addr, en_wr;
  logic       busy, prog_done, wel_clr, err;

  page_program_seq #(.ADDR_BITS(32)) dut (
    .clkm(clkm), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .mode(mode),
    .beat(beat), .cs_end(cs_end), .wel(wel), .mem_ready(mem_ready),
    .en_addr(en_addr), .en_write_buf(en_write_buf), .en_read_buf(en_read_buf),
    .save_start_addr(save_start_addr), .en_wr(en_wr), .busy(busy),
    .prog_done(prog_done), .wel_clr(wel_clr), .err(err)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Event monitor, sampled mid-cycle.
  int n_addr = 0, n_wb = 0, n_rb = 0, n_save = 0, n_wr = 0;
  int n_done = 0, n_wclr = 0, n_err = 0, n_viol = 0;
  int cyc = 0, last_cs_cyc = 0, save_lat = 0;
  logic prev_ready = 1'b0, prev_wr = 1'b0;

  always @(negedge clkm) begin
    cyc <= cyc + 1;
    if (en_addr)         n_addr <= n_addr + 1;
    if (en_write_buf)    n_wb   <= n_wb + 1;
    if (en_read_buf)     n_rb   <= n_rb + 1;
    if (save_start_addr) n_save <= n_save + 1;
    if (en_wr)           n_wr   <= n_wr + 1;
    if (prog_done)       n_done <= n_done + 1;
    if (wel_clr)         n_wclr <= n_wclr + 1;
    if (err)             n_err  <= n_err + 1;
    if (cs_end)          last_cs_cyc <= cyc;
    if (save_start_addr) save_lat <= cyc - last_cs_cyc;
    // en_wr needs mem_ready in the previous cycle and a gap after a prior pulse;
    // the buffer strobes must never fire while programming.
    if ((en_wr && (!prev_ready || prev_wr)) ||
        (busy && (en_addr || en_write_buf || en_read_buf)))
      n_viol <= n_viol + 1;
    prev_ready <= mem_ready;
    prev_wr    <= en_wr;
  end

  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  task automatic tick();
    @(posedge clkm);
    #1;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input bit m, input bit w);
    cmd_valid = 1'b1; cmd = op; mode = m; wel = w;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic end_cs();
    cs_end = 1'b1;
    tick();
    cs_end = 1'b0;
  endtask

  task automatic wait_idle(input bit inject);
    int k = 0;
    while (busy && k < 5000) begin
      if (inject && k == 2) begin
        cmd_valid = 1'b1; cmd = OP_READ; mode = 1'b1; wel = 1'b1; beat = 1'b1; cs_end = 1'b1;
        tick();
        cmd_valid = 1'b0; beat = 1'b0; cs_end = 1'b0;
      end else begin
        tick();
      end
      k++;
    end
    check("busy_bounded", int'(k < 5000), 1);
    tick();
    tick();
  endtask

  // One complete chip-select transaction plus its expected event counts.
  task automatic run_txn(input string name, input logic [7:0] op, input bit m, input bit w,
                         input int na, input int nd, input int rmode, input bit inject);
    int s_addr = n_addr, s_wb = n_wb, s_rb = n_rb, s_save = n_save, s_wr = n_wr;
    int s_done = n_done, s_wclr = n_wclr, s_err = n_err;
    int nb = m ? NB_OPI : NB_SPI;
    bit is_pp = (op == OP_PP);
    bit is_rd = (op == OP_READ);
    bit accepted = (is_pp && w) || is_rd;
    bit aborted  = accepted && (na < nb);
    int bytes, load;
    int e_addr, e_wb, e_rb, e_wr, e_prog, e_err;

    ready_mode = rmode;
    send_cmd(op, m, w);
    send_beats(na);
    if (accepted && !aborted) send_beats(nd);
    end_cs();
    wait_idle(inject);

    bytes  = (accepted && !aborted) ? (m ? nd : nd / 8) : 0;
    load   = (bytes > PAGE_BYTES) ? PAGE_BYTES : bytes;
    e_addr = accepted ? ((na < nb) ? na : nb) : 0;
    e_wb   = is_pp ? bytes : 0;
    e_rb   = is_rd ? bytes : 0;
    e_wr   = is_pp ? load : 0;
    e_prog = (is_pp && load > 0) ? 1 : 0;
    e_err  = ((is_pp && !w) || aborted) ? 1 : 0;

    check({name, "/en_addr"},      n_addr - s_addr, e_addr);
    check({name, "/en_write_buf"}, n_wb - s_wb,     e_wb);
    check({name, "/en_read_buf"},  n_rb - s_rb,     e_rb);
    check({name, "/save_start"},   n_save - s_save, e_prog);
    check({name, "/en_wr"},        n_wr - s_wr,     e_wr);
    check({name, "/prog_done"},    n_done - s_done, e_prog);
    check({name, "/wel_clr"},      n_wclr - s_wclr, e_prog);
    check({name, "/err"},          n_err - s_err,   e_err);
    check({name, "/protocol"},     n_viol,          0);
    if (e_prog == 1) check({name, "/save_latency"}, save_lat, 1);
  endtask

  function automatic int outs_vec();
    return int'({en_addr, en_write_buf, en_read_buf, save_start_addr, en_wr,
                 busy, prog_done, wel_clr, err});
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 8'h00; mode = 1'b0; beat = 1'b0;
    cs_end = 1'b0; wel = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", outs_vec(), 0);
    rst_n = 1'b1;
    tick();

    run_txn("spi_pp_3B",     OP_PP,   1'b0, 1'b1, NB_SPI, 24,  0, 1'b0);
    run_txn("opi_pp_300",    OP_PP,   1'b1, 1'b1, NB_OPI, 300, 0, 1'b0);
    run_txn("pp_no_wel",     OP_PP,   1'b1, 1'b0, NB_OPI, 0,   0, 1'b0);
    run_txn("pp_abort_2",    OP_PP,   1'b1, 1'b1, 2,      0,   0, 1'b0);
    run_txn("pp_zero_data",  OP_PP,   1'b1, 1'b1, NB_OPI, 0,   0, 1'b0);
    run_txn("spi_pp_partial",OP_PP,   1'b0, 1'b1, NB_SPI, 7,   0, 1'b0);
    run_txn("pp_toggle_inj", OP_PP,   1'b1, 1'b1, NB_OPI, 12,  1, 1'b1);
    run_txn("spi_read",      OP_READ, 1'b0, 1'b1, NB_SPI, 20,  0, 1'b0);
    run_txn("other_opcode",  8'h05,   1'b1, 1'b1, NB_OPI, 5,   0, 1'b0);

    // Reset while programming.
    ready_mode = 1;
    send_cmd(OP_PP, 1'b1, 1'b1);
    send_beats(NB_OPI);
    send_beats(10);
    end_cs();
    repeat (4) tick();
    check("busy_mid_prog", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_mid_prog_outputs", outs_vec(), 0);
    tick();
    run_txn("read_after_reset", OP_READ, 1'b1, 1'b1, NB_OPI, 9, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      int sel = $urandom_range(0, 9);
      logic [7:0] op = (sel < 6) ? OP_PP : ((sel < 9) ? OP_READ : 8'h9F);
      bit m = 1'($urandom_range(0, 1));
      bit w = ($urandom_range(0, 5) != 0);
      int nb = m ? NB_OPI : NB_SPI;
      int na = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : nb;
      int nd = m ? $urandom_range(0, 300) : $urandom_range(0, 40);
      run_txn($sformatf("rand%0d", t), op, m, w, na, nd, 2, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
